// File: rtl/cpu_mc.sv
// Multi-cycle accumulator-free RISC core: FETCH -> DECODE -> EXEC per instruction,
// with a small flop-based register file and a one-word-per-request fetch port.
module cpu_mc #(
  parameter int XLEN  = 32,
  parameter int NREGS = 8,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            retire,
  output logic            halted,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     debug_inst,
  output logic [XLEN-1:0] debug_data
);

  localparam int RW = $clog2(NREGS);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] opa, opb;

  logic [3:0]      op;
  logic [RW-1:0]   rd, rs1, rs2;
  logic [15:0]     imm;
  logic [XLEN-1:0] imm_sx;
  logic [PC_W-1:0] jmp_target, pc_inc, pc_next;
  logic [XLEN-1:0] alu_res;
  logic            wr_en;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[(i < 16) ? i : 15];
    return r;
  endfunction

  function automatic logic [PC_W-1:0] zext16(input logic [15:0] v);
    logic [PC_W-1:0] r;
    for (int i = 0; i < PC_W; i++) r[i] = (i < 16) ? v[(i < 16) ? i : 15] : 1'b0;
    return r;
  endfunction

  assign op         = ir[31:28];
  assign rd         = ir[24 +: RW];
  assign rs1        = ir[20 +: RW];
  assign rs2        = ir[16 +: RW];
  assign imm        = ir[15:0];
  assign imm_sx     = sext16(imm);
  assign jmp_target = zext16(imm);
  assign pc_inc     = pc + PC_W'(1);

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    wr_en   = 1'b0;
    pc_next = pc_inc;
    case (op)
      OP_ADD:  begin alu_res = opa + opb;    wr_en = 1'b1; end
      OP_SUB:  begin alu_res = opa - opb;    wr_en = 1'b1; end
      OP_AND:  begin alu_res = opa & opb;    wr_en = 1'b1; end
      OP_OR:   begin alu_res = opa | opb;    wr_en = 1'b1; end
      OP_XOR:  begin alu_res = opa ^ opb;    wr_en = 1'b1; end
      OP_ADDI: begin alu_res = opa + imm_sx; wr_en = 1'b1; end
      OP_JMP:  pc_next = jmp_target;
      OP_BEQ:  if (opa == opb) pc_next = jmp_target;
      OP_HALT: pc_next = pc;
      default: ;
    endcase
  end

  // NOTE: the register file is a handful of flops, so it is cleared with the rest of the
  // state; a RAM-mapped file could not be reset this way. State uses non-blocking updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      opa        <= '0;
      opb        <= '0;
      debug_data <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          opa   <= (rs1 == '0) ? '0 : regs[rs1];
          opb   <= (rs2 == '0) ? '0 : regs[rs2];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (wr_en && rd != '0) begin
            regs[rd]   <= alu_res;
            debug_data <= alu_res;
          end
          pc    <= pc_next;
          state <= (op == OP_HALT) ? S_HALT : S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Status outputs decode the state register; gating with reset makes a mid-instruction
  // reset drop the request and suppress the retire pulse in the very cycle it is asserted.
  assign imem_req   = (state == S_FETCH) && !reset;
  assign retire     = (state == S_EXEC)  && !reset;
  assign halted     = (state == S_HALT)  && !reset;
  assign imem_addr  = pc;
  assign debug_inst = ir;

endmodule

// File: tb/tb_cpu_mc.sv
// Bench for cpu_mc: two instances (default and XLEN=8/PC_W=4) run the same programs,
// each with an ISA model feeding a scoreboard that is checked on every retire.
module tb_cpu_mc;

  localparam logic [31:0] NOP_W = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        reset;
  int          delay;
  logic [31:0] prog [32];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [31:0] fetch_word(input logic [63:0] a);
    return (a < 64'd32) ? prog[a[4:0]] : NOP_W;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LX = (g == 0) ? 32 : 8;
    localparam int LP = (g == 0) ? 32 : 4;

    typedef struct {
      logic [LP-1:0] pc;
      logic [LX-1:0] data;
      logic [31:0]   inst;
    } exp_t;

    logic          imem_req, imem_ack, retire, halted;
    logic [LP-1:0] imem_addr, pc;
    logic [31:0]   imem_rdata, debug_inst;
    logic [LX-1:0] debug_data;

    logic [LX-1:0] m_regs [8];
    logic [LP-1:0] m_pc, held_addr;
    logic [LX-1:0] m_data;
    exp_t          sb [$];
    exp_t          cur;
    bit            pending;
    int            wait_cnt, n_retire, edges, halt_at;

    cpu_mc #(.XLEN(LX), .NREGS(8), .PC_W(LP)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .retire     (retire),
      .halted     (halted),
      .pc         (pc),
      .debug_inst (debug_inst),
      .debug_data (debug_data)
    );

    always @(posedge clk) edges <= reset ? 0 : edges + 1;

    // Reference ISA model: executes each fetched word and queues the architectural result.
    task automatic model_step(input logic [31:0] inst);
      logic [63:0]   sx;
      logic [63:0]   zx;
      logic [LX-1:0] a, b, res;
      logic [LP-1:0] nxt;
      bit            wr;
      sx  = {{48{inst[15]}}, inst[15:0]};
      zx  = {48'h0, inst[15:0]};
      a   = m_regs[inst[22:20]];
      b   = m_regs[inst[18:16]];
      nxt = m_pc + LP'(1);
      wr  = 1'b1;
      res = '0;
      case (inst[31:28])
        4'd0: res = a + b;
        4'd1: res = a - b;
        4'd2: res = a & b;
        4'd3: res = a | b;
        4'd4: res = a ^ b;
        4'd5: res = a + sx[LX-1:0];
        4'd6: begin wr = 1'b0; nxt = zx[LP-1:0]; end
        4'd7: begin wr = 1'b0; if (a == b) nxt = zx[LP-1:0]; end
        4'd8: begin wr = 1'b0; nxt = m_pc; end
        default: wr = 1'b0;
      endcase
      if (wr && inst[26:24] != 3'd0) begin
        m_regs[inst[26:24]] = res;
        m_data = res;
      end
      sb.push_back('{pc: nxt, data: m_data, inst: inst});
      m_pc = nxt;
    endtask

    // Memory responder + scoreboard monitor, evaluated just after each falling edge.
    always @(negedge clk) begin
      #1;
      if (reset) begin
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_pc = '0; m_data = '0; sb.delete(); pending = 0;
        wait_cnt = 0; n_retire = 0; halt_at = -1;
        imem_ack = 1'b0; imem_rdata = '0;
      end else begin
        if (pending) begin
          check($sformatf("l%0d_pc_after_retire", g), pc, cur.pc);
          check($sformatf("l%0d_debug_data", g), debug_data, cur.data);
          pending = 0;
        end
        if (retire) begin
          n_retire++;
          check($sformatf("l%0d_retire_expected", g), 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            check($sformatf("l%0d_debug_inst", g), debug_inst, cur.inst);
            pending = 1;
          end
        end
        if (halted && halt_at < 0) halt_at = edges;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        if (imem_req) begin
          if (wait_cnt == 0) check($sformatf("l%0d_fetch_addr", g), imem_addr, m_pc);
          else               check($sformatf("l%0d_addr_stable", g), imem_addr, held_addr);
          held_addr = imem_addr;
          if (wait_cnt >= delay) begin
            imem_ack   = 1'b1;
            imem_rdata = fetch_word(64'(imem_addr));
            model_step(imem_rdata);
            wait_cnt   = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          if (wait_cnt != 0) begin
            check($sformatf("l%0d_req_stable", g), imem_req, 1'b1);
            wait_cnt = 0;
          end
          // Stray acks carrying a HALT word outside FETCH must be ignored.
          if (delay > 0) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'h8000_0000;
          end
        end
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = NOP_W;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("l0_rst_req",    lane[0].imem_req,   1'b0);
    check("l0_rst_retire", lane[0].retire,     1'b0);
    check("l0_rst_halted", lane[0].halted,     1'b0);
    check("l0_rst_pc",     lane[0].pc,         64'd0);
    check("l0_rst_ir",     lane[0].debug_inst, 64'd0);
    check("l0_rst_data",   lane[0].debug_data, 64'd0);
    check("l1_rst_req",    lane[1].imem_req,   1'b0);
    check("l1_rst_halted", lane[1].halted,     1'b0);
    check("l1_rst_pc",     lane[1].pc,         64'd0);
    check("l1_rst_data",   lane[1].debug_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("l0_first_req",  lane[0].imem_req,  1'b1);
    check("l0_first_addr", lane[0].imem_addr, 64'd0);
    check("l1_first_req",  lane[1].imem_req,  1'b1);
  endtask

  task automatic run_to_halt(input string tag, input int exp_at, input int exp_ret);
    int n = 0;
    while (!(lane[0].halted && lane[1].halted) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #2;
    check({tag, "_halt_in_time"}, 64'(n < 1000), 64'd1);
    check({tag, "_l0_halt_cycle"}, 64'(lane[0].halt_at), 64'(exp_at));
    check({tag, "_l1_halt_cycle"}, 64'(lane[1].halt_at), 64'(exp_at));
    check({tag, "_l0_retires"}, 64'(lane[0].n_retire), 64'(exp_ret));
    check({tag, "_l1_retires"}, 64'(lane[1].n_retire), 64'(exp_ret));
    check({tag, "_l0_sb_empty"}, 64'(lane[0].sb.size()), 64'd0);
  endtask

  task automatic load_p1();
    clear_prog();
    prog[0] = enc(4'd5, 4'd1, 4'd0, 4'd0, 16'd5);
    prog[1] = enc(4'd5, 4'd2, 4'd0, 4'd0, 16'hFFFD);
    prog[2] = enc(4'd0, 4'd3, 4'd1, 4'd2, 16'd0);
    prog[3] = enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    delay = 0;

    // Basic program, ack in the first FETCH cycle: 3 cycles per instruction.
    load_p1();
    do_reset();
    run_to_halt("p1", 12, 4);
    check("p1_l0_r3", lane[0].debug_data, 64'd2);
    check("p1_l1_r3", lane[1].debug_data, 64'd2);
    check("p1_l0_pc", lane[0].pc, 64'd3);

    // Delayed acks; first a reset lands mid-wait and must abort the fetch.
    delay = 4;
    do_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #2;
    check("abort_l0_req", lane[0].imem_req, 1'b0);
    check("abort_l1_req", lane[1].imem_req, 1'b0);
    check("abort_l1_retire", lane[1].retire, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("restart_l1_req",  lane[1].imem_req,  1'b1);
    check("restart_l1_addr", lane[1].imem_addr, 64'd0);
    run_to_halt("p1_slow", 28, 4);
    check("p1s_l0_r3", lane[0].debug_data, 64'd2);
    check("p1s_l1_r3", lane[1].debug_data, 64'd2);

    // Reset during EXEC: no retire that cycle and the register write is lost.
    delay = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lane[0].retire) break;
    end
    check("exec_seen", lane[0].retire, 1'b1);
    reset = 1'b1;
    #2;
    check("exec_abort_l0_retire", lane[0].retire, 1'b0);
    check("exec_abort_l1_retire", lane[1].retire, 1'b0);
    @(negedge clk);
    #2;
    check("exec_abort_data", lane[0].debug_data, 64'd0);
    check("exec_abort_pc",   lane[0].pc,         64'd0);

    // Branch not taken, jump, halt at the jump target.
    clear_prog();
    prog[0] = enc(4'd5, 4'd1, 4'd0, 4'd0, 16'd7);
    prog[1] = enc(4'd7, 4'd0, 4'd1, 4'd0, 16'd9);
    prog[2] = enc(4'd6, 4'd0, 4'd0, 4'd0, 16'd5);
    prog[3] = enc(4'd5, 4'd7, 4'd0, 4'd0, 16'd1);
    prog[5] = enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd0);
    prog[9] = enc(4'd5, 4'd6, 4'd0, 4'd0, 16'd1);
    do_reset();
    run_to_halt("p2", 12, 4);
    check("p2_l0_pc", lane[0].pc, 64'd5);
    check("p2_l1_pc", lane[1].pc, 64'd5);
    check("p2_l0_data", lane[0].debug_data, 64'd7);

    // Logic ops, SUB, taken BEQ, write to r0 discarded; one wait cycle plus stray acks.
    clear_prog();
    prog[0]  = enc(4'd5, 4'd1, 4'd0, 4'd0, 16'h0F0F);
    prog[1]  = enc(4'd5, 4'd2, 4'd0, 4'd0, 16'h00FF);
    prog[2]  = enc(4'd2, 4'd3, 4'd1, 4'd2, 16'd0);
    prog[3]  = enc(4'd3, 4'd4, 4'd1, 4'd2, 16'd0);
    prog[4]  = enc(4'd4, 4'd5, 4'd1, 4'd2, 16'd0);
    prog[5]  = enc(4'd1, 4'd6, 4'd2, 4'd1, 16'd0);
    prog[6]  = enc(4'd7, 4'd0, 4'd3, 4'd3, 16'd10);
    prog[7]  = enc(4'd5, 4'd7, 4'd0, 4'd0, 16'd1);
    prog[8]  = enc(4'd5, 4'd7, 4'd0, 4'd0, 16'd1);
    prog[10] = enc(4'd0, 4'd0, 4'd1, 4'd2, 16'd0);
    prog[11] = enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd0);
    delay = 1;
    do_reset();
    run_to_halt("p5", 36, 9);
    check("p5_l0_data", lane[0].debug_data, 64'hFFFF_F1F0);
    check("p5_l1_data", lane[1].debug_data, 64'hF0);
    check("p5_l0_pc",   lane[0].pc,         64'd11);

    // 8-bit wrap and sign handling; ADDI to r0 leaves debug_data alone.
    clear_prog();
    prog[0] = enc(4'd5, 4'd1, 4'd0, 4'd0, 16'h007F);
    prog[1] = enc(4'd5, 4'd1, 4'd1, 4'd0, 16'h0001);
    prog[2] = enc(4'd5, 4'd1, 4'd1, 4'd0, 16'h0080);
    prog[3] = enc(4'd5, 4'd0, 4'd0, 4'd0, 16'h0001);
    prog[4] = enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd0);
    delay = 0;
    do_reset();
    run_to_halt("p3", 15, 5);
    check("p3_l1_data", lane[1].debug_data, 64'h00);
    check("p3_l0_data", lane[0].debug_data, 64'h100);

    // Sixteen NOPs: the 4-bit pc wraps to 0, the 32-bit pc reaches 16 and halts.
    clear_prog();
    prog[16] = enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd0);
    do_reset();
    repeat (48) @(negedge clk);
    #2;
    check("wrap_l1_req",  lane[1].imem_req,  1'b1);
    check("wrap_l1_addr", lane[1].imem_addr, 64'd0);
    check("wrap_l0_addr", lane[0].imem_addr, 64'd16);
    repeat (3) @(negedge clk);
    #2;
    check("wrap_l0_halted", lane[0].halted, 1'b1);
    check("wrap_l0_pc",     lane[0].pc,     64'd16);
    check("wrap_l1_halted", lane[1].halted, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
